alu_operand_stage: RTL

- Single-entry pipeline register directly upstream of the 16-bit ALU.
- Accepts decoded instructions from decode through a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM and writeback write buses, then drives the ALU's InA, InB, Cin, Oper, invA, invB and sign from registered state.
- Inserts bubbles for load-use hazards and supports a pipeline flush.

---
 rtl/alu_operand_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand stage directly upstream of the 16-bit ALU: captures decoded instructions,
// forwards from the EX/MEM and writeback buses, and holds load-use dependents as bubbles.
module alu_operand_stage #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int NUM_OPERATIONS = 3,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [OPERAND_WIDTH-1:0]  id_rs_data,
    input  logic [OPERAND_WIDTH-1:0]  id_rt_data,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic [OPERAND_WIDTH-1:0]  id_imm,
    input  logic                      id_use_imm,
    input  logic [NUM_OPERATIONS-1:0] id_oper,
    input  logic                      id_cin,
    input  logic                      id_invA,
    input  logic                      id_invB,
    input  logic                      id_sign,
    input  logic                      exm_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] exm_wr_addr,
    input  logic [OPERAND_WIDTH-1:0]  exm_wr_data,
    input  logic                      exm_is_load,
    input  logic                      wb_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_wr_addr,
    input  logic [OPERAND_WIDTH-1:0]  wb_wr_data,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [OPERAND_WIDTH-1:0]  InA,
    output logic [OPERAND_WIDTH-1:0]  InB,
    output logic                      Cin,
    output logic [NUM_OPERATIONS-1:0] Oper,
    output logic                      invA,
    output logic                      invB,
    output logic                      sign
);

    logic                      valid_q, valid_d;
    logic                      a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic [OPERAND_WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
    logic                      rs_used_q, rs_used_d, rt_fwd_q, rt_fwd_d;
    logic [NUM_OPERATIONS-1:0] oper_q, oper_d;
    logic                      cin_q, cin_d, inva_q, inva_d, invb_q, invb_d, sign_q, sign_d;
    logic                      ex_valid_s, fire_out_s, accept_s;
    logic [OPERAND_WIDTH:0]    fwd_a_s, fwd_b_s;

    // Returns {pend, value}; EX/MEM beats writeback, an in-flight load marks the operand pending.
    function automatic logic [OPERAND_WIDTH:0] fwd(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic                      used,
        input logic [OPERAND_WIDTH-1:0]  dflt,
        input logic                      x_en,
        input logic [REG_ADDR_WIDTH-1:0] x_addr,
        input logic [OPERAND_WIDTH-1:0]  x_data,
        input logic                      x_ld,
        input logic                      w_en,
        input logic [REG_ADDR_WIDTH-1:0] w_addr,
        input logic [OPERAND_WIDTH-1:0]  w_data
    );
        logic [OPERAND_WIDTH:0] r;
        if (!used) begin
            r = {1'b0, dflt};
        end else if (x_en && (x_addr == addr) && x_ld) begin
            r = {1'b1, dflt};
        end else if (x_en && (x_addr == addr)) begin
            r = {1'b0, x_data};
        end else if (w_en && (w_addr == addr)) begin
            r = {1'b0, w_data};
        end else begin
            r = {1'b0, dflt};
        end
        return r;
    endfunction

    assign ex_valid_s = valid_q & ~a_pend_q & ~b_pend_q;
    assign fire_out_s = ex_valid_s & ex_ready;
    assign id_ready   = ~flush & (~valid_q | fire_out_s);
    assign accept_s   = id_valid & id_ready;

    assign ex_valid = ex_valid_s;
    assign InA      = a_q;
    assign InB      = b_q;
    assign Cin      = cin_q;
    assign Oper     = oper_q;
    assign invA     = inva_q;
    assign invB     = invb_q;
    assign sign     = sign_q;

    // Next-state selection: flush, then accept, then re-snoop of a held entry, then drain.
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        a_pend_d  = a_pend_q;
        b_pend_d  = b_pend_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rs_used_d = rs_used_q;
        rt_fwd_d  = rt_fwd_q;
        oper_d    = oper_q;
        cin_d     = cin_q;
        inva_d    = inva_q;
        invb_d    = invb_q;
        sign_d    = sign_q;
        fwd_a_s   = {1'b0, a_q};
        fwd_b_s   = {1'b0, b_q};
        if (flush) begin
            valid_d  = 1'b0;
            a_pend_d = 1'b0;
            b_pend_d = 1'b0;
        end else if (accept_s) begin
            fwd_a_s = fwd(id_rs_addr, id_rs_used, id_rs_data, exm_wr_en, exm_wr_addr,
                          exm_wr_data, exm_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
            if (id_use_imm) begin
                fwd_b_s = {1'b0, id_imm};
            end else begin
                fwd_b_s = fwd(id_rt_addr, id_rt_used, id_rt_data, exm_wr_en, exm_wr_addr,
                              exm_wr_data, exm_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
            end
            valid_d   = 1'b1;
            a_pend_d  = fwd_a_s[OPERAND_WIDTH];
            a_d       = fwd_a_s[OPERAND_WIDTH-1:0];
            b_pend_d  = fwd_b_s[OPERAND_WIDTH];
            b_d       = fwd_b_s[OPERAND_WIDTH-1:0];
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rs_used_d = id_rs_used;
            rt_fwd_d  = id_rt_used & ~id_use_imm;
            oper_d    = id_oper;
            cin_d     = id_cin;
            inva_d    = id_invA;
            invb_d    = id_invB;
            sign_d    = id_sign;
        end else if (valid_q && !fire_out_s) begin
            fwd_a_s  = fwd(rs_addr_q, rs_used_q, a_q, exm_wr_en, exm_wr_addr,
                           exm_wr_data, exm_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
            fwd_b_s  = fwd(rt_addr_q, rt_fwd_q, b_q, exm_wr_en, exm_wr_addr,
                           exm_wr_data, exm_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
            a_pend_d = fwd_a_s[OPERAND_WIDTH];
            a_d      = fwd_a_s[OPERAND_WIDTH-1:0];
            b_pend_d = fwd_b_s[OPERAND_WIDTH];
            b_d      = fwd_b_s[OPERAND_WIDTH-1:0];
        end else if (fire_out_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register; async reset discards the entry immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            a_q       <= {OPERAND_WIDTH{1'b0}};
            b_q       <= {OPERAND_WIDTH{1'b0}};
            a_pend_q  <= 1'b0;
            b_pend_q  <= 1'b0;
            rs_addr_q <= {REG_ADDR_WIDTH{1'b0}};
            rt_addr_q <= {REG_ADDR_WIDTH{1'b0}};
            rs_used_q <= 1'b0;
            rt_fwd_q  <= 1'b0;
            oper_q    <= {NUM_OPERATIONS{1'b0}};
            cin_q     <= 1'b0;
            inva_q    <= 1'b0;
            invb_q    <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_pend_q  <= a_pend_d;
            b_pend_q  <= b_pend_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_used_q <= rs_used_d;
            rt_fwd_q  <= rt_fwd_d;
            oper_q    <= oper_d;
            cin_q     <= cin_d;
            inva_q    <= inva_d;
            invb_q    <= invb_d;
            sign_q    <= sign_d;
        end
    end

endmodule
